sound_sequencer: RTL and testbench
==================================

SOUND_SEQUENCER -- requirements
Module: sound_sequencer

Interface
REQ-001 Parameter SCALE, default 64: clocks per half-period code unit.
REQ-002 Parameter NOTE_CYC, default 4096: clocks per note.
REQ-003 Parameter GAP_CYC, default 512: clocks of silence between notes.
REQ-004 Port clk, input, 1: sole clock; all state SHALL update on its rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port good_coll, input, 1: single-cycle pulse, snake ate food; triggers EAT sound.
REQ-007 Port bad_coll, input, 1: single-cycle pulse, snake crashed; triggers DIE sound.
REQ-008 Port mute, input, 1: level; when high, at_max is forced low and timing is unaffected.
REQ-009 Port at_max, output, 1: square-wave gate to the downstream DAC ramp counter (high = ramp, low = clear).
REQ-010 Port playing, output, 1: high while a sound sequence is active (PLAY or GAP).

Function
REQ-011 The FSM SHALL have states IDLE, PLAY, GAP.
REQ-012 Sequence tables (half-period codes) SHALL be fixed: EAT = {4, 2}; DIE = {3, 5, 7, 9}.
REQ-013 The half-period of a note SHALL be code*SCALE clocks; the multiply SHALL be computed at a width that cannot overflow for code <= 9.
REQ-014 IDLE: at_max = 0, playing = 0, all counters held at 0.
REQ-015 A trigger accepted in any state SHALL, on the next edge, load the sequence, set note index = 0, clear the duration and half-period counters, set the gate phase high, and enter PLAY.
REQ-016 at_max SHALL be 1 in the first cycle of PLAY (unless muted).
REQ-017 PLAY: the half-period counter SHALL count 0..code*SCALE-1; on wrap the gate phase SHALL toggle; at_max = gate phase AND NOT mute.
REQ-018 PLAY SHALL last exactly NOTE_CYC cycles, after which the FSM SHALL go to GAP if notes remain, otherwise to IDLE.
REQ-019 GAP: at_max = 0, playing = 1; GAP SHALL last exactly GAP_CYC cycles, then the note index SHALL increment and the FSM SHALL enter PLAY with the gate phase high and counters cleared.
REQ-020 Priority: bad_coll SHALL override good_coll when both are high in the same cycle; DIE is played.
REQ-021 If bad_coll arrives during EAT, EAT SHALL abort and DIE SHALL restart from note 0.
REQ-022 If good_coll arrives during DIE, it SHALL be ignored.
REQ-023 If good_coll arrives during EAT, EAT SHALL restart from note 0.
REQ-024 If bad_coll arrives during DIE, DIE SHALL restart from note 0.
REQ-025 mute SHALL NOT alter state, counters, playing, or sequence length.
REQ-026 Total sequence length SHALL be n*NOTE_CYC + (n-1)*GAP_CYC cycles, where n is the number of notes.

Reset
REQ-027 While rst is high at an edge: state = IDLE, at_max = 0, playing = 0, all counters, the note index and the gate phase = 0.
REQ-028 rst SHALL take priority over simultaneous triggers; rst mid-sequence SHALL abort with no further at_max activity until a new trigger.
REQ-029 at_max and playing SHALL be registered outputs, glitch-free, with 1-cycle latency from the state change.

Verification (SCALE=1, NOTE_CYC=16, GAP_CYC=4)
REQ-030 EAT check: rst, then a good_coll pulse -> playing = 1 for 36 cycles; note 0 at_max toggles every 4 cycles (4 high, 4 low, x2); 4 low (GAP); note 1 toggles every 2 cycles; then IDLE.
REQ-031 DIE check: bad_coll pulse -> playing = 1 for 4*16 + 3*4 = 76 cycles, with half-periods 3, 5, 7, 9 in order.
REQ-032 Same-cycle check: good_coll and bad_coll high together -> DIE sequence, 76 cycles.
REQ-033 Preemption and ignore check: bad_coll at cycle 10 of EAT -> DIE restarts, playing continuous, 76 further cycles; good_coll during DIE -> no change to timing.
REQ-034 Mute and reset check: mute held for a whole EAT -> at_max = 0 throughout and playing = 1 for 36 cycles; rst asserted mid-DIE -> next cycle at_max = 0, playing = 0, and IDLE is held.

Source files
------------

// File: rtl/sound_sequencer.sv
// Sound sequencer: plays fixed square-wave note sequences (EAT / DIE) on a
// 1-bit gate for a downstream DAC ramp counter, with silent gaps between notes.
module sound_sequencer #(
  parameter int unsigned SCALE    = 64,   // clocks per half-period code unit
  parameter int unsigned NOTE_CYC = 4096, // clocks per note
  parameter int unsigned GAP_CYC  = 512   // clocks of silence between notes
) (
  input  logic clk,
  input  logic rst,
  input  logic good_coll,
  input  logic bad_coll,
  input  logic mute,
  output logic at_max,
  output logic playing
);

  typedef enum logic [1:0] {StIdle, StPlay, StGap} state_e;

  localparam int unsigned MaxCyc = (NOTE_CYC > GAP_CYC) ? NOTE_CYC : GAP_CYC;
  localparam int unsigned DurW   = $clog2(MaxCyc + 1);
  // Wide enough for the largest code (9) times SCALE.
  localparam int unsigned HalfW  = $clog2(9 * SCALE + 1);

  state_e           r_state, w_state_d;
  logic             r_is_die, w_is_die_d;
  logic [1:0]       r_idx, w_idx_d;
  logic [DurW-1:0]  r_dur, w_dur_d;
  logic [HalfW-1:0] r_half, w_half_d;
  logic             r_phase, w_phase_d;
  logic             r_at_max, r_playing;

  logic [3:0]       w_code;
  logic [HalfW-1:0] w_half_len;
  logic [1:0]       w_last_idx;
  logic             w_trig, w_trig_die, w_trig_eat;

  // Half-period code lookup for the current sequence and note.
  always_comb begin
    w_code = 4'd0;
    if (r_is_die) begin
      unique case (r_idx)
        2'd0: w_code = 4'd3;
        2'd1: w_code = 4'd5;
        2'd2: w_code = 4'd7;
        2'd3: w_code = 4'd9;
        default: w_code = 4'd0;
      endcase
    end else begin
      unique case (r_idx)
        2'd0: w_code = 4'd4;
        2'd1: w_code = 4'd2;
        default: w_code = 4'd0;
      endcase
    end
  end

  assign w_half_len = HalfW'(w_code) * HalfW'(SCALE);
  assign w_last_idx = r_is_die ? 2'd3 : 2'd1;

  // DIE always wins; EAT is dropped while a DIE sequence is active.
  assign w_trig_die = bad_coll;
  assign w_trig_eat = good_coll && !bad_coll && !(r_is_die && (r_state != StIdle));
  assign w_trig     = w_trig_die || w_trig_eat;

  // Next-state, counter and output-next logic.
  always_comb begin
    w_state_d  = r_state;
    w_is_die_d = r_is_die;
    w_idx_d    = r_idx;
    w_dur_d    = r_dur;
    w_half_d   = r_half;
    w_phase_d  = r_phase;

    unique case (r_state)
      StIdle: begin
        w_idx_d   = 2'd0;
        w_dur_d   = '0;
        w_half_d  = '0;
        w_phase_d = 1'b0;
      end
      StPlay: begin
        if (r_dur == DurW'(NOTE_CYC - 1)) begin
          w_dur_d   = '0;
          w_half_d  = '0;
          w_phase_d = 1'b0;
          if (r_idx == w_last_idx) begin
            w_state_d = StIdle;
            w_idx_d   = 2'd0;
          end else begin
            w_state_d = StGap;
          end
        end else begin
          w_dur_d = r_dur + DurW'(1);
          if (r_half == w_half_len - HalfW'(1)) begin
            w_half_d  = '0;
            w_phase_d = ~r_phase;
          end else begin
            w_half_d = r_half + HalfW'(1);
          end
        end
      end
      StGap: begin
        if (r_dur == DurW'(GAP_CYC - 1)) begin
          w_state_d = StPlay;
          w_dur_d   = '0;
          w_half_d  = '0;
          w_phase_d = 1'b1;
          w_idx_d   = r_idx + 2'd1;
        end else begin
          w_dur_d = r_dur + DurW'(1);
        end
      end
      default: w_state_d = StIdle;
    endcase

    if (w_trig) begin
      w_state_d  = StPlay;
      w_is_die_d = w_trig_die;
      w_idx_d    = 2'd0;
      w_dur_d    = '0;
      w_half_d   = '0;
      w_phase_d  = 1'b1;
    end
  end

  // State, counters and registered outputs; outputs track the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_is_die  <= 1'b0;
      r_idx     <= 2'd0;
      r_dur     <= '0;
      r_half    <= '0;
      r_phase   <= 1'b0;
      r_at_max  <= 1'b0;
      r_playing <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_is_die  <= w_is_die_d;
      r_idx     <= w_idx_d;
      r_dur     <= w_dur_d;
      r_half    <= w_half_d;
      r_phase   <= w_phase_d;
      r_at_max  <= (w_state_d == StPlay) && w_phase_d && !mute;
      r_playing <= (w_state_d != StIdle);
    end
  end

  assign at_max  = r_at_max;
  assign playing = r_playing;

endmodule

// File: tb/tb_sound_sequencer.sv
// Directed bench for sound_sequencer with SCALE=1, NOTE_CYC=16, GAP_CYC=4.
module tb_sound_sequencer;

  localparam int NoteCyc = 16;
  localparam int GapCyc  = 4;

  logic clk = 1'b0;
  logic rst, good_coll, bad_coll, mute;
  logic at_max, playing;

  int checks = 0;
  int errors = 0;

  sound_sequencer #(
    .SCALE   (1),
    .NOTE_CYC(NoteCyc),
    .GAP_CYC (GapCyc)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .good_coll(good_coll),
    .bad_coll (bad_coll),
    .mute     (mute),
    .at_max   (at_max),
    .playing  (playing)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Half-period codes from the fixed tables.
  function automatic int exp_code(input bit die, input int idx);
    int eat_tab[2] = '{4, 2};
    int die_tab[4] = '{3, 5, 7, 9};
    return die ? die_tab[idx] : eat_tab[idx];
  endfunction

  task automatic pulse(input bit g, input bit b);
    good_coll = g;
    bad_coll  = b;
    step();
    good_coll = 1'b0;
    bad_coll  = 1'b0;
  endtask

  // Checks a full sequence starting at its first PLAY cycle; optional good_coll at cycle ign_at.
  task automatic check_seq(input bit die, input bit muted, input int ign_at, input string name);
    int n     = die ? 4 : 2;
    int total = n * NoteCyc + (n - 1) * GapCyc;
    for (int c = 0; c < total; c++) begin
      int note = c / (NoteCyc + GapCyc);
      int off  = c % (NoteCyc + GapCyc);
      int h    = exp_code(die, note);
      logic exp_at = (off < NoteCyc) && (((off / h) % 2) == 0) && !muted;
      checks++;
      if (playing !== 1'b1) begin
        errors++;
        $display("FAIL %s playing cycle %0d: got %b want 1", name, c, playing);
      end
      checks++;
      if (at_max !== exp_at) begin
        errors++;
        $display("FAIL %s at_max cycle %0d: got %b want %b", name, c, at_max, exp_at);
      end
      good_coll = (c == ign_at);
      step();
    end
    good_coll = 1'b0;
    checks++;
    if (playing !== 1'b0 || at_max !== 1'b0) begin
      errors++;
      $display("FAIL %s end idle: got playing=%b at_max=%b want 0 0", name, playing, at_max);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (playing !== 1'b0 || at_max !== 1'b0) begin
      errors++;
      $display("FAIL reset: got playing=%b at_max=%b want 0 0", playing, at_max);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_rst_priority();
    rst       = 1'b1;
    good_coll = 1'b1;
    bad_coll  = 1'b1;
    step();
    rst       = 1'b0;
    good_coll = 1'b0;
    bad_coll  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (playing !== 1'b0 || at_max !== 1'b0) begin
        errors++;
        $display("FAIL rst_priority cycle %0d: got playing=%b at_max=%b want 0 0",
                 i, playing, at_max);
      end
      step();
    end
  endtask

  task automatic test_eat();
    pulse(1'b1, 1'b0);
    check_seq(1'b0, 1'b0, -1, "eat");
    step();
  endtask

  task automatic test_die();
    pulse(1'b0, 1'b1);
    check_seq(1'b1, 1'b0, -1, "die");
    step();
  endtask

  task automatic test_same_cycle();
    pulse(1'b1, 1'b1);
    check_seq(1'b1, 1'b0, -1, "same_cycle");
    step();
  endtask

  task automatic test_preempt_ignore();
    pulse(1'b1, 1'b0);
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (playing !== 1'b1) begin
        errors++;
        $display("FAIL preempt eat playing cycle %0d: got %b want 1", c, playing);
      end
      step();
    end
    pulse(1'b0, 1'b1);
    check_seq(1'b1, 1'b0, 20, "preempt_die");
    step();
  endtask

  task automatic test_eat_restart();
    pulse(1'b1, 1'b0);
    for (int c = 0; c < 25; c++) step();
    pulse(1'b1, 1'b0);
    check_seq(1'b0, 1'b0, -1, "eat_restart");
    step();
  endtask

  task automatic test_mute();
    mute = 1'b1;
    pulse(1'b1, 1'b0);
    check_seq(1'b0, 1'b1, -1, "mute");
    mute = 1'b0;
    step();
  endtask

  task automatic test_rst_mid();
    pulse(1'b0, 1'b1);
    for (int c = 0; c < 30; c++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      checks++;
      if (playing !== 1'b0 || at_max !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid cycle %0d: got playing=%b at_max=%b want 0 0",
                 i, playing, at_max);
      end
      step();
    end
  endtask

  initial begin
    rst       = 1'b1;
    good_coll = 1'b0;
    bad_coll  = 1'b0;
    mute      = 1'b0;
    #1;
    test_reset();
    test_rst_priority();
    test_eat();
    test_die();
    test_eat();
    test_same_cycle();
    test_preempt_ignore();
    test_eat_restart();
    test_mute();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
